// File: rtl/rf_pkg.sv
// rf_pkg: shared function-select encoding and the wrap-detect helper for the register file.
package rf_pkg;
  typedef enum logic [1:0] {
    FS_DEC  = 2'b00,
    FS_INC  = 2'b01,
    FS_LOAD = 2'b10,
    FS_CLR  = 2'b11
  } fun_sel_e;

  // q is zero-extended to 64 bits; w is the real register width.
  function automatic logic wrap_f(input fun_sel_e fs, input logic [63:0] q, input int unsigned w);
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (fs == FS_INC && q == mx) || (fs == FS_DEC && q == 64'd0);
  endfunction
endpackage

// File: rtl/rf_cell.sv
// rf_cell: one register applying dec/inc/load/clear when enabled, flagging modular wrap.
module rf_cell
  import rf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             e,
  input  fun_sel_e         fun_sel,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = !e                  ? q_q :
          fun_sel == FS_DEC   ? q_q - WIDTH'(1) :
          fun_sel == FS_INC   ? q_q + WIDTH'(1) :
          fun_sel == FS_LOAD  ? i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  end

  assign q    = q_q;
  assign wrap = e & wrap_f(fun_sel, 64'(q_q), WIDTH);
endmodule

// File: rtl/rf_param.sv
// rf_param: NT temporaries + NR general registers on one write bus, two async read ports.
// Define RF_BYPASS_EN to forward a same-cycle load of the selected register to its read port.
module rf_param
  import rf_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NR    = 4,
  parameter  int NT    = 4,
  localparam int SELW  = $clog2(NR + NT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       fun_sel,
  input  logic [NR-1:0]    r_sel,
  input  logic [NT-1:0]    t_sel,
  input  logic [WIDTH-1:0] i,
  input  logic [SELW-1:0]  o1_sel,
  input  logic [SELW-1:0]  o2_sel,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic             o1_z,
  output logic             o2_z,
  output logic             ovf
);
  localparam int N = NR + NT;
  localparam int M = 2 ** SELW;

  fun_sel_e         fs;
  logic [M-1:0]     en, wrap;
  logic [WIDTH-1:0] q [M];
  logic             ovf_q, ovf_d;

  assign fs = fun_sel_e'(fun_sel);

  // Slots past N are tied to zero so every select value reads 0 without a range check.
  for (genvar g = 0; g < M; g++) begin : g_slot
    if (g < NT) begin : g_t
      assign en[g] = t_sel[NT-1-g];
    end else if (g < N) begin : g_r
      assign en[g] = r_sel[N-1-g];
    end else begin : g_off
      assign en[g] = 1'b0;
    end
    if (g < N) begin : g_reg
      rf_cell #(.WIDTH(WIDTH)) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .e      (en[g]),
        .fun_sel(fs),
        .i      (i),
        .q      (q[g]),
        .wrap   (wrap[g])
      );
    end else begin : g_pad
      assign q[g]    = '0;
      assign wrap[g] = 1'b0;
    end
  end

  assign ovf_d = |wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end

`ifdef RF_BYPASS_EN
  assign o1 = (fs == FS_LOAD && en[o1_sel]) ? i : q[o1_sel];
  assign o2 = (fs == FS_LOAD && en[o2_sel]) ? i : q[o2_sel];
`else
  assign o1 = q[o1_sel];
  assign o2 = q[o2_sel];
`endif

  assign o1_z = (o1 == '0);
  assign o2_z = (o2 == '0);
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_rf_param.sv
// tb_rf_param: randomized check of rf_param against an array model, plus directed scenarios.
module tb_rf_param;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] fs = 2'b00;
  logic [3:0] r_sel = '0, t_sel = '0;
  logic [7:0] d = '0;
  logic [2:0] s1 = '0, s2 = '0;
  logic [7:0] o1, o2;
  logic       o1_z, o2_z, ovf;

  logic [1:0] fs3 = 2'b00;
  logic [2:0] r3 = '0, t3 = '0, a3 = '0, b3 = '0;
  logic [7:0] d3 = '0;
  logic [7:0] p1, p2;
  logic       z1, z2, v3;

  int m [8];
  bit mo;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  rf_param dut (
    .clk(clk), .rst_n(rst_n), .fun_sel(fs), .r_sel(r_sel), .t_sel(t_sel), .i(d),
    .o1_sel(s1), .o2_sel(s2), .o1(o1), .o2(o2), .o1_z(o1_z), .o2_z(o2_z), .ovf(ovf)
  );

  rf_param #(.WIDTH(8), .NR(3), .NT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .fun_sel(fs3), .r_sel(r3), .t_sel(t3), .i(d3),
    .o1_sel(a3), .o2_sel(b3), .o1(p1), .o2(p2), .o1_z(z1), .o2_z(z2), .ovf(v3)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Read index k: 0..3 are T1..T4, 4..7 are R1..R4; mask MSB is register 1.
  function automatic bit en_of(int k);
    return k < 4 ? t_sel[3-k] : r_sel[7-k];
  endfunction

  function automatic int expect_rd(int k);
`ifdef RF_BYPASS_EN
    if (fs == 2'b10 && en_of(k)) return int'(d);
`endif
    return m[k];
  endfunction

  task automatic model_edge();
    int nm [8];
    bit w;
    w = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nm[k] = m[k];
      if (en_of(k)) begin
        case (fs)
          2'b00: begin w |= (m[k] == 0); nm[k] = (m[k] + 255) % 256; end
          2'b01: begin w |= (m[k] == 255); nm[k] = (m[k] + 1) % 256; end
          2'b10: nm[k] = int'(d);
          default: nm[k] = 0;
        endcase
      end
    end
    m = nm;
    mo = w;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic [1:0] f, input logic [3:0] r, input logic [3:0] t, input logic [7:0] v);
    fs = f; r_sel = r; t_sel = t; d = v;
    step();
  endtask

  // Pulse reset mid-cycle and check outputs clear without waiting for a clock edge.
  task automatic do_reset(input bit check);
    fs = 2'b00; r_sel = '0; t_sel = '0;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 8; k++) m[k] = 0;
    mo = 1'b0;
    #1;
    if (check) begin
      chk("rst_o1", o1, 0);
      chk("rst_o1_z", o1_z, 1);
      chk("rst_ovf", ovf, 0);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("o1", o1, expect_rd(int'(s1)));
        chk("o2", o2, expect_rd(int'(s2)));
        chk("o1_z", o1_z, expect_rd(int'(s1)) == 0);
        chk("o2_z", o2_z, expect_rd(int'(s2)) == 0);
        chk("ovf", ovf, mo);
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) m[k] = 0;
    mo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_o1", o1, 0);
    chk("init_o2_z", o2_z, 1);
    chk("init_ovf", ovf, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();
    op(2'b10, 4'hF, 4'hF, 8'h5A);
    s1 = 3'd0;
    #1 chk("pre_rst_o1", o1, 8'h5A);
    do_reset(1'b1);
    op(2'b10, 4'b1010, 4'b0000, 8'h3C);
    s1 = 3'd4; s2 = 3'd5;
    #1 chk("r1_load", o1, 8'h3C);
    chk("r2_hold", o2, 8'h00);
    chk("model_r1", m[4], 8'h3C);
    s1 = 3'd6; s2 = 3'd7;
    #1 chk("r3_load", o1, 8'h3C);
    chk("r4_hold", o2, 8'h00);
    op(2'b10, 4'b0000, 4'b0100, 8'hFF);
    op(2'b01, 4'b0000, 4'b0100, 8'h00);
    s1 = 3'd1;
    #1 chk("t2_wrap", o1, 8'h00);
    chk("t2_z", o1_z, 1);
    chk("ovf_up", ovf, 1);
    op(2'b00, 4'b0000, 4'b0000, 8'h00);
    chk("ovf_idle", ovf, 0);
    op(2'b00, 4'b0001, 4'b0000, 8'h00);
    s1 = 3'd7;
    #1 chk("r4_wrap_dn", o1, 8'hFF);
    chk("ovf_dn", ovf, 1);
    op(2'b10, 4'b0001, 4'b0000, 8'h01);
    op(2'b00, 4'b0001, 4'b0000, 8'h00);
    chk("r4_dec0", o1, 8'h00);
    chk("ovf_dec0", ovf, 0);
    s1 = 3'd0; fs = 2'b10; r_sel = '0; t_sel = 4'b1000; d = 8'hA5;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_pre", o1, 8'hA5);
`else
    chk("byp_pre", o1, 8'h00);
`endif
    step();
    chk("byp_post", o1, 8'hA5);
    fs3 = 2'b10; r3 = 3'b111; t3 = 3'b111; d3 = 8'h11;
    op(2'b00, 4'b0000, 4'b0000, 8'h00);
    a3 = 3'd0; b3 = 3'd6;
    #1 chk("n3_t1", p1, 8'h11);
    chk("n3_oor6", p2, 8'h00);
    a3 = 3'd5; b3 = 3'd7;
    #1 chk("n3_r3", p1, 8'h11);
    chk("n3_oor7", p2, 8'h00);
    fs3 = 2'b11;
    op(2'b00, 4'b0000, 4'b0000, 8'h00);
    fs3 = 2'b00; r3 = '0; t3 = '0;
    for (int k = 0; k < 6; k++) begin
      a3 = 3'(k);
      #1 chk("n3_clr", p1, 8'h00);
      chk("n3_clr_z", z1, 1);
    end
    chk("n3_ovf", v3, 0);
    for (int n = 0; n < 400; n++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      s1 = 3'($urandom);
      s2 = ($urandom_range(0, 7) == 0) ? s1 : 3'($urandom);
      if ($urandom_range(0, 63) == 0) do_reset(1'b0);
      else op(2'($urandom), 4'($urandom), 4'($urandom), v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
